adc_spi_sequencer: RTL

Conversion sequencer for the SPI ADC front end. It turns a start request into a complete conversion: it drives `cnv` high, waits out the conversion time, and clocks out a burst of `sck` edges while shifting in `sdo`. The finished sample is presented on a valid/ready output port. It sits between the ADC pins and the downstream sample consumer, and owns all `sck`/`cnv` sequencing.

---
 rtl/adc_spi_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer
//   Turns a start request into one SPI ADC conversion: a cnv strobe, a
//   conversion wait, then DATA_W sck periods that shift sdo in MSB first.
//   The sample is offered on a valid/ready port; overrun pulses when an
//   unconsumed sample is replaced.
//   Optional feature macro: ADC_SEQ_AUTOTRIG_EN adds auto_en/period and an
//   internal periodic trigger ORed with start.
//   Every pin output is a register fed from the current FSM state, so each
//   pin changes one edge after the state that asks for it.
//   Handshake: data is transferred on every edge where valid && ready; valid
//   stays high and data stays stable until then, except that a new sample
//   from DONE replaces the old one and sets valid again on that edge.
//   state_dbg exposes the FSM state (0 = IDLE).
module adc_spi_sequencer #(
   parameter int DATA_W     = 16,
   parameter int CNV_CYCLES = 4,
   parameter int CONV_WAIT  = 8,
   parameter int SCK_HALF   = 1,
   parameter int PERIOD_W   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
`ifdef ADC_SEQ_AUTOTRIG_EN
   input  logic                auto_en,
   input  logic [PERIOD_W-1:0] period,
`endif
   output logic                busy,
   output logic                cnv,
   output logic                sck,
   input  logic                sdo,
   output logic [DATA_W-1:0]   data,
   output logic                valid,
   input  logic                ready,
   output logic                overrun,
   output logic [2:0]          state_dbg
);

   localparam int MAX_A   = (CNV_CYCLES > CONV_WAIT) ? CNV_CYCLES : CONV_WAIT;
   localparam int MAX_CNT = (MAX_A > SCK_HALF) ? MAX_A : SCK_HALF;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int BIT_W   = $clog2(DATA_W + 1);

   localparam logic [CNT_W-1:0] CNV_LAST  = CNT_W'(CNV_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CONV_WAIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCK_HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CNV   = 3'd1,
      S_WAIT  = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [BIT_W-1:0]  bit_cnt, bit_nx;
   logic              half_hi, half_hi_nx;
   logic [DATA_W-1:0] shift_reg;
   logic              go;
   logic              sample_bit;

`ifdef ADC_SEQ_AUTOTRIG_EN
   logic [PERIOD_W-1:0] auto_cnt;
   logic                auto_fire;

   assign auto_fire = auto_en && (auto_cnt == period);
   assign go        = start || auto_fire;

   // Free-running trigger counter; wraps every period+1 cycles while enabled.
   always_ff @(posedge clk) begin
      if (reset || !auto_en) begin
         auto_cnt <= '0;
      end else if (auto_cnt == period) begin
         auto_cnt <= '0;
      end else begin
         auto_cnt <= auto_cnt + PERIOD_W'(1);
      end
   end
`else
   assign go = start;
`endif

   // The first cycle of each low half is the edge on which sck falls.
   assign sample_bit = (state == S_SHIFT) && !half_hi && (cnt == '0);
   assign state_dbg  = state;

   // FSM and sequencing counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         half_hi <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_cnt <= bit_nx;
         half_hi <= half_hi_nx;
      end
   end

   // Next-state logic; start is only looked at in IDLE, so requests while busy vanish.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_nx     = bit_cnt;
      half_hi_nx = half_hi;
      unique case (state)
         S_IDLE: begin
            cnt_nx = '0;
            if (go) begin
               state_nx = S_CNV;
            end
         end
         S_CNV: begin
            if (cnt == CNV_LAST) begin
               state_nx = S_WAIT;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (cnt == WAIT_LAST) begin
               state_nx   = S_SHIFT;
               cnt_nx     = '0;
               bit_nx     = '0;
               half_hi_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         S_SHIFT: begin
            if (cnt == HALF_LAST) begin
               cnt_nx     = '0;
               half_hi_nx = !half_hi;
               if (!half_hi) begin
                  if (bit_cnt == BIT_LAST) begin
                     state_nx = S_DONE;
                  end else begin
                     bit_nx = bit_cnt + BIT_W'(1);
                  end
               end
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Registered pins, shift register and the output port.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnv       <= 1'b0;
         busy      <= 1'b0;
         sck       <= 1'b0;
         shift_reg <= '0;
         data      <= '0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         cnv  <= (state == S_CNV);
         busy <= (state == S_CNV) || (state == S_WAIT) || (state == S_SHIFT);
         sck  <= (state == S_SHIFT) && half_hi;
         if (sample_bit) begin
            shift_reg <= {shift_reg[DATA_W-2:0], sdo};
         end
         if (state == S_DONE) begin
            data    <= shift_reg;
            valid   <= 1'b1;
            overrun <= valid && !ready;
         end else begin
            overrun <= 1'b0;
            if (valid && ready) begin
               valid <= 1'b0;
            end
         end
      end
   end

endmodule
